// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin packet multiplexer.
package rr_pkg;

   typedef enum logic {IDLE, LOCK} state_t;

   // Helpers operate on a fixed-width container; callers size-cast to N.
   localparam int MAX_N = 32;

   function automatic logic [MAX_N-1:0] rotl_onehot(input logic [MAX_N-1:0] v, input int n);
      logic [MAX_N-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (i < n && v[i]) r[(i + 1) % n] = 1'b1;
      end
      return r;
   endfunction

   function automatic int onehot_to_idx(input logic [MAX_N-1:0] v);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_N; i++) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority one-hot picker: first request at or above prio, wrapping to bit 0.
module rr_pick #(
   parameter int N = 3
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] prio,
   output logic [N-1:0] pick
);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] masked;

   // The borrow ripples from prio up to the first set request; a wrap lands in the upper copy.
   assign dbl    = {req, req};
   assign masked = dbl & ~(dbl - {{N{1'b0}}, prio});
   assign pick   = masked[N-1:0] | masked[2*N-1:N];

endmodule

// File: rtl/rr_packet_mux.sv
// Packet-aware N-to-1 valid/ready mux with round-robin arbitration and one output register slice.
// Optional beat limit with truncation flag: define RR_PACKET_MUX_BEAT_LIMIT_EN.
module rr_packet_mux
   import rr_pkg::*;
#(
   parameter int N         = 3,
   parameter int DW        = 32,
   parameter int SW        = $clog2(N),
   parameter int MAX_BEATS = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   input  logic [N*DW-1:0] in_data,
   input  logic [N-1:0]    in_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_data,
   output logic            out_last,
   output logic [SW-1:0]   out_src
`ifdef RR_PACKET_MUX_BEAT_LIMIT_EN
   ,
   output logic            err_trunc
`endif
);

   state_t        state;
   logic [N-1:0]  prio;
   logic [N-1:0]  grant;
   logic [N-1:0]  pick;
   logic [DW-1:0] sel_data;
   logic          sel_last;
   logic          out_en;
   logic          accept;
   logic          limit_hit;
   logic          emit_last;
   logic          release_pkt;

   rr_pick #(.N(N)) u_pick (
      .req  (in_valid),
      .prio (prio),
      .pick (pick)
   );

   assign out_en   = !out_valid || out_ready;
   assign in_ready = (state == LOCK) ? (grant & {N{out_en}}) : '0;
   assign accept   = |(in_valid & in_ready);

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            sel_data = in_data[i*DW +: DW];
            sel_last = in_last[i];
         end
      end
   end

`ifdef RR_PACKET_MUX_BEAT_LIMIT_EN
   localparam int CW = $clog2(MAX_BEATS + 1);
   logic [CW-1:0] beat_cnt;

   assign limit_hit = (beat_cnt == CW'(MAX_BEATS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt  <= '0;
         err_trunc <= 1'b0;
      end else begin
         err_trunc <= release_pkt && limit_hit && !sel_last;
         if (release_pkt)  beat_cnt <= '0;
         else if (accept)  beat_cnt <= beat_cnt + 1'b1;
      end
   end
`else
   assign limit_hit = 1'b0;
`endif

   assign emit_last   = sel_last || limit_hit;
   assign release_pkt = accept && emit_last;

   // Arbitration: grant is held from the IDLE pick until the packet's final beat is accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         prio  <= N'(1);
         grant <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|in_valid) begin
                  grant <= pick;
                  state <= LOCK;
               end
            end
            LOCK: begin
               if (release_pkt) begin
                  state <= IDLE;
                  prio  <= N'(rotl_onehot(MAX_N'(grant), N));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output register slice.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_last  <= emit_last;
         out_src   <= SW'(onehot_to_idx(MAX_N'(grant)));
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_packet_mux.sv
// Directed bench for rr_packet_mux: arbitration order, lock, backpressure, single beats, reset, beat limit.
module tb_rr_packet_mux;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int SW = $clog2(N);

   logic            clk;
   logic            rst;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_last;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic [SW-1:0]   out_src;
`ifdef RR_PACKET_MUX_BEAT_LIMIT_EN
   logic            err_trunc;
`endif

   rr_packet_mux #(.N(N), .DW(DW), .MAX_BEATS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_src   (out_src)
`ifdef RR_PACKET_MUX_BEAT_LIMIT_EN
      ,
      .err_trunc (err_trunc)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Source model: tot beats left, plen beats per packet, seq beats sent so far.
   int tot [N];
   int plen[N];
   int seq [N];

   int src_q[$], dat_q[$], lst_q[$], cyc_q[$], err_q[$];
   int exp_src[$], exp_dat[$], exp_lst[$];
   int cyc;
   int rdy0_cnt;
   bit watch0;
   int err_cnt;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         in_valid[i]          = (tot[i] > 0);
         in_last[i]           = (((seq[i] + 1) % plen[i]) == 0);
         in_data[i*DW +: DW]  = DW'((i << 8) | seq[i]);
      end
   endtask

   task automatic step();
      logic [N-1:0] hs;
      @(negedge clk);
      hs = in_valid & in_ready;
      if (watch0 && in_ready[0]) rdy0_cnt++;
      if (out_valid && out_ready) begin
         src_q.push_back(int'(out_src));
         dat_q.push_back(int'(out_data));
         lst_q.push_back(int'(out_last));
         cyc_q.push_back(cyc);
`ifdef RR_PACKET_MUX_BEAT_LIMIT_EN
         err_q.push_back(int'(err_trunc));
`endif
      end
`ifdef RR_PACKET_MUX_BEAT_LIMIT_EN
      if (err_trunc) err_cnt++;
`endif
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            seq[i]++;
            tot[i]--;
         end
      end
      drive();
   endtask

   task automatic run_until(input int n, input string tag);
      int b;
      b = 0;
      while (src_q.size() < n && b < 200) begin
         step();
         b++;
      end
      chk_val(tag, src_q.size(), n);
   endtask

   task automatic clear_log();
      src_q.delete(); dat_q.delete(); lst_q.delete(); cyc_q.delete(); err_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         tot[i] = 0; plen[i] = 1; seq[i] = 0;
      end
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      clear_log();
   endtask

   task automatic check_log(input string tag);
      for (int k = 0; k < exp_src.size(); k++) begin
         if (k < src_q.size()) begin
            chk_val($sformatf("%s_src%0d", tag, k), src_q[k], exp_src[k]);
            chk_val($sformatf("%s_dat%0d", tag, k), dat_q[k], exp_dat[k]);
            chk_val($sformatf("%s_lst%0d", tag, k), lst_q[k], exp_lst[k]);
         end else begin
            chk_val($sformatf("%s_missing%0d", tag, k), 0, 1);
         end
      end
   endtask

   initial begin
      cyc = 0; rdy0_cnt = 0; watch0 = 1'b0; err_cnt = 0;
      in_valid = '0; in_last = '0; in_data = '0;
      rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         tot[i] = 0; plen[i] = 1; seq[i] = 0;
      end
      #12;
      chk_val("rst_out_valid", out_valid, 0);
      chk_val("rst_out_data",  out_data,  0);
      chk_val("rst_out_last",  out_last,  0);
      chk_val("rst_out_src",   out_src,   0);
      chk_val("rst_in_ready",  in_ready,  0);

      // all three channels, 2-beat packets, channel 0 has two packets
      do_reset();
      tot = '{4, 2, 2}; plen = '{2, 2, 2};
      drive();
      run_until(8, "t1_count");
      exp_src = '{0, 0, 1, 1, 2, 2, 0, 0};
      exp_dat = '{'h000, 'h001, 'h100, 'h101, 'h200, 'h201, 'h002, 'h003};
      exp_lst = '{0, 1, 0, 1, 0, 1, 0, 1};
      check_log("t1");
      for (int k = 1; k < 8 && k < cyc_q.size(); k++)
         chk_val($sformatf("t1_gap%0d", k), cyc_q[k] - cyc_q[k-1], (k % 2 == 1) ? 1 : 2);

      // channel 1 locked while channel 0 requests mid-packet
      do_reset();
      tot[1] = 4; plen[1] = 4;
      drive();
      begin
         int b;
         b = 0;
         while (seq[1] < 1 && b < 50) begin step(); b++; end
      end
      tot[0] = 2; plen[0] = 2;
      drive();
      watch0 = 1'b1;
      begin
         int b;
         b = 0;
         while (seq[1] < 4 && b < 50) begin step(); b++; end
      end
      watch0 = 1'b0;
      run_until(6, "t2_count");
      chk_val("t2_rdy0_during_lock", rdy0_cnt, 0);
      exp_src = '{1, 1, 1, 1, 0, 0};
      exp_dat = '{'h100, 'h101, 'h102, 'h103, 'h000, 'h001};
      exp_lst = '{0, 0, 0, 1, 0, 1};
      check_log("t2");

      // backpressure for 5 cycles while beat 1 is held
      do_reset();
      tot[0] = 4; plen[0] = 4;
      drive();
      run_until(1, "t3_first");
      out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk_val($sformatf("t3_hold_vld%0d", s), out_valid, 1);
         chk_val($sformatf("t3_hold_dat%0d", s), out_data, 'h001);
         chk_val($sformatf("t3_hold_lst%0d", s), {out_last, out_src}, 0);
         chk_val($sformatf("t3_hold_rdy%0d", s), in_ready, 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      run_until(4, "t3_count");
      repeat (3) step();
      chk_val("t3_no_extra", src_q.size(), 4);
      exp_src = '{0, 0, 0, 0};
      exp_dat = '{'h000, 'h001, 'h002, 'h003};
      exp_lst = '{0, 0, 0, 1};
      check_log("t3");

      // single-beat packets on channel 2, then all three to probe prio
      do_reset();
      tot[2] = 3; plen[2] = 1;
      drive();
      run_until(3, "t4_count");
      for (int k = 1; k < 3 && k < cyc_q.size(); k++)
         chk_val($sformatf("t4_gap%0d", k), cyc_q[k] - cyc_q[k-1], 2);
      tot = '{1, 1, 1}; plen = '{1, 1, 1};
      drive();
      run_until(6, "t4_count2");
      exp_src = '{2, 2, 2, 0, 1, 2};
      exp_dat = '{'h200, 'h201, 'h202, 'h000, 'h100, 'h203};
      exp_lst = '{1, 1, 1, 1, 1, 1};
      check_log("t4");

      // asynchronous reset in the middle of a 5-beat packet
      do_reset();
      tot[1] = 5; plen[1] = 5;
      drive();
      run_until(2, "t5_pre");
      chk_val("t5_pre_vld", out_valid, 1);
      #2;
      rst = 1'b0;
      #1;
      chk_val("t5_async_vld", out_valid, 0);
      chk_val("t5_async_rdy", in_ready, 0);
      for (int i = 0; i < N; i++) begin
         tot[i] = 0; seq[i] = 0; plen[i] = 1;
      end
      drive();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      clear_log();
      tot = '{0, 1, 1};
      drive();
      @(negedge clk);
      chk_val("t5_idle_rdy", in_ready, 0);
      run_until(2, "t5_count");
      exp_src = '{1, 2};
      exp_dat = '{'h100, 'h200};
      exp_lst = '{1, 1};
      check_log("t5");

`ifdef RR_PACKET_MUX_BEAT_LIMIT_EN
      // beat limit of 4 truncates a 6-beat packet on channel 0
      do_reset();
      err_cnt = 0;
      tot = '{6, 1, 0}; plen = '{6, 1, 1};
      drive();
      run_until(7, "t6_count");
      exp_src = '{0, 0, 0, 0, 1, 0, 0};
      exp_dat = '{'h000, 'h001, 'h002, 'h003, 'h100, 'h004, 'h005};
      exp_lst = '{0, 0, 0, 1, 1, 0, 1};
      check_log("t6");
      if (err_q.size() > 3) chk_val("t6_err_on_beat4", err_q[3], 1);
      else chk_val("t6_err_missing", 0, 1);
      chk_val("t6_err_pulses", err_cnt, 1);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
